// File: rtl/fadd_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready back-pressure.
// Flush-to-zero inputs, round-to-nearest-even, saturating overflow, tag passed through.
module fadd_pipe #(
  parameter int EW   = 8,
  parameter int MW   = 23,
  parameter int TAGW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW:0]    x1,
  input  logic [EW+MW:0]    x2,
  input  logic              sub,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW:0]    y,
  output logic              ovf,
  output logic [TAGW-1:0]   out_tag
);

  localparam int W   = 1 + EW + MW;
  localparam int SW  = MW + 4;             // hidden bit + mantissa + guard/round/sticky
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EW-1:0] EMAX = '1;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic [SW-1:0] align(input logic [MW:0] sig, input logic [EW-1:0] sh);
    logic [2*SW-1:0] wide;
    logic [SW-1:0]   al;
    if (int'(sh) >= MW + 3) begin
      return {{(SW-1){1'b0}}, |sig};
    end
    wide = {sig, {(SW+3){1'b0}}} >> sh;
    al   = wide[2*SW-1:SW];
    return {al[SW-1:1], al[0] | (|wide[SW-1:0])};
  endfunction

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) n = LZW'(SW - 1 - i);
    end
    return n;
  endfunction

  function automatic logic [MW+1:0] round_rne(input logic [SW-1:0] n);
    logic [MW:0] m;
    logic        inc;
    m   = n[SW-1:3];
    inc = n[2] & (n[1] | n[0] | m[0]);
    return {1'b0, m} + (MW+2)'(inc);
  endfunction

  // Returns {ovf, y}; saturates to signed infinity when the exponent reaches all-ones.
  function automatic logic [W:0] pack_result(input logic sgn, input logic signed [EW+1:0] ex,
                                             input logic [MW+1:0] rnd);
    logic signed [EW+1:0] ef;
    ef = $signed(ex + (EW+2)'(rnd[MW+1]));
    if (ef >= $signed({2'b00, EMAX})) begin
      return {1'b1, sgn, EMAX, {MW{1'b0}}};
    end
    return {1'b0, sgn, ef[EW-1:0], rnd[MW-1:0]};
  endfunction

  // ---- S1: unpack, effective signs, magnitude swap, alignment ----
  logic            se1, se2, z1, z2, inf1, inf2, swap_s1;
  logic [EW-1:0]   e1, e2, ea_s1, eb_s1;
  logic [EW+MW-1:0] key1, key2;
  logic [MW:0]     sig1, sig2, siga_s1, sigb_s1;
  logic            sa_s1, sb_s1;

  always_comb begin
    se1  = x1[W-1];
    se2  = x2[W-1] ^ sub;
    e1   = x1[W-2:MW];
    e2   = x2[W-2:MW];
    z1   = (e1 == '0);
    z2   = (e2 == '0);
    inf1 = (e1 == EMAX);
    inf2 = (e2 == EMAX);
    sig1 = z1 ? '0 : {1'b1, x1[MW-1:0]};
    sig2 = z2 ? '0 : {1'b1, x2[MW-1:0]};
    key1 = z1 ? '0 : x1[W-2:0];
    key2 = z2 ? '0 : x2[W-2:0];
    swap_s1 = key2 > key1;
    if (swap_s1) begin
      sa_s1 = se2; ea_s1 = e2; siga_s1 = sig2;
      sb_s1 = se1; eb_s1 = e1; sigb_s1 = sig1;
    end else begin
      sa_s1 = se1; ea_s1 = e1; siga_s1 = sig1;
      sb_s1 = se2; eb_s1 = e2; sigb_s1 = sig2;
    end
  end

  logic                  vld_p1, sgn_p1, eff_sub_p1, both_neg_p1, spec_p1, spec_sgn_p1;
  logic [EW-1:0]         exp_p1;
  logic [SW-1:0]         siga_p1, sigb_p1;
  logic [TAGW-1:0]       tag_p1;

  always_ff @(posedge clk) begin
    if (adv) begin
      sgn_p1      <= sa_s1;
      eff_sub_p1  <= sa_s1 ^ sb_s1;
      both_neg_p1 <= se1 & se2;
      spec_p1     <= inf1 | inf2;
      spec_sgn_p1 <= inf1 ? se1 : se2;
      exp_p1      <= ea_s1;
      siga_p1     <= {siga_s1, 3'b000};
      sigb_p1     <= align(sigb_s1, ea_s1 - eb_s1);
      tag_p1      <= in_tag;
    end
  end

  // ---- S2: add/subtract, leading-zero count, normalise ----
  logic [SW:0]           sum_s2;
  logic [SW-1:0]         norm_s2;
  logic [LZW-1:0]        lz_s2;
  logic signed [EW+1:0]  exp_s2;
  logic                  zero_s2;

  always_comb begin
    sum_s2  = eff_sub_p1 ? ({1'b0, siga_p1} - {1'b0, sigb_p1})
                         : ({1'b0, siga_p1} + {1'b0, sigb_p1});
    zero_s2 = (sum_s2 == '0);
    lz_s2   = lzc(sum_s2[SW-1:0]);
    if (sum_s2[SW]) begin
      norm_s2 = {sum_s2[SW:2], sum_s2[1] | sum_s2[0]};
      exp_s2  = $signed({2'b00, exp_p1} + (EW+2)'(1));
    end else begin
      norm_s2 = sum_s2[SW-1:0] << lz_s2;
      exp_s2  = $signed({2'b00, exp_p1} - (EW+2)'(lz_s2));
    end
  end

  logic                  vld_p2, sgn_p2, both_neg_p2, spec_p2, spec_sgn_p2, zero_p2;
  logic signed [EW+1:0]  exp_p2;
  logic [SW-1:0]         norm_p2;
  logic [TAGW-1:0]       tag_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      sgn_p2      <= sgn_p1;
      both_neg_p2 <= both_neg_p1;
      spec_p2     <= spec_p1;
      spec_sgn_p2 <= spec_sgn_p1;
      zero_p2     <= zero_s2;
      exp_p2      <= exp_s2;
      norm_p2     <= norm_s2;
      tag_p2      <= tag_p1;
    end
  end

  // ---- S3: round, exponent adjust, pack, flags ----
  logic [W:0] res_s3;

  always_comb begin
    if (spec_p2) begin
      res_s3 = {1'b0, spec_sgn_p2, EMAX, {MW{1'b0}}};
    end else if (zero_p2) begin
      res_s3 = {1'b0, both_neg_p2, {(W-1){1'b0}}};
    end else if (exp_p2[EW+1] || exp_p2 == '0) begin
      res_s3 = {1'b0, sgn_p2, {(W-1){1'b0}}};
    end else begin
      res_s3 = pack_result(sgn_p2, exp_p2, round_rne(norm_p2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      y         <= res_s3[W-1:0];
      ovf       <= res_s3[W];
      out_tag   <= tag_p2;
    end
  end

endmodule
